// File: rtl/operand_tf_pkg.sv
// operand_tf_pkg: shared types and helpers for the operand transformer scaler
package operand_tf_pkg;
  typedef enum logic {SCALE_ALIGN = 1'b0, SCALE_SAT = 1'b1} scale_mode_e;
  function automatic int mag_w(input int elem_w);
    return elem_w - 1;
  endfunction
endpackage

// File: rtl/sm_scale_lane.sv
// sm_scale_lane: one sign-magnitude lane, leading-one detect in S1, shift/overflow into S2
module sm_scale_lane
  import operand_tf_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int SCALE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s1_load,
  input  logic               s2_load,
  input  logic [ELEM_W-1:0]  elem,
  input  logic [SCALE_W-1:0] scale,
  input  scale_mode_e        mode,
  output logic [ELEM_W-1:0]  out_elem,
  output logic               out_ovf
);
  localparam int MAG_W = mag_w(ELEM_W);
  localparam int P_W   = $clog2(MAG_W + 1);
  logic [P_W-1:0]    p;
  logic [P_W-1:0]    s1_p;
  logic [P_W-1:0]    al_amt;
  logic              s1_zero;
  logic [ELEM_W-1:0] s1_elem;
  logic [MAG_W-1:0]  m;
  logic [MAG_W-1:0]  sh;
  logic [MAG_W-1:0]  al;
  logic [MAG_W-1:0]  mag;
  logic [SCALE_W:0]  sum;
  logic              ovf;
  // leading-one position of the incoming magnitude (highest set bit wins)
  always_comb begin
    p = '0;
    for (int i = 0; i < MAG_W; i++) p = elem[i] ? P_W'(i) : p;
  end
  // S1: element, leading-one position and zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_elem <= '0;
      s1_p    <= '0;
      s1_zero <= 1'b1;
    end else if (s1_load) begin
      s1_elem <= elem;
      s1_p    <= p;
      s1_zero <= elem[MAG_W-1:0] == '0;
    end
  end
  // one extra bit keeps p + scale from wrapping
  assign m      = s1_elem[MAG_W-1:0];
  assign sum    = {1'b0, scale} + (SCALE_W+1)'(s1_p);
  assign ovf    = !s1_zero && sum > (SCALE_W+1)'(MAG_W - 1);
  assign sh     = m << scale;
  assign al_amt = P_W'(MAG_W - 1) - s1_p;
  assign al     = m << al_amt;
  assign mag    = !ovf ? sh : (mode == SCALE_SAT) ? '1 : al;
  // S2: scaled element and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_elem <= '0;
      out_ovf  <= 1'b0;
    end else if (s2_load) begin
      out_elem <= {s1_elem[ELEM_W-1], mag};
      out_ovf  <= ovf;
    end
  end
endmodule

// File: rtl/sm_scale_pipe.sv
// sm_scale_pipe: two-stage multi-lane power-of-two scaler; SM_SCALE_PIPE_OVF_CNT_EN adds the overflow counter
module sm_scale_pipe
  import operand_tf_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ELEM_W    = 8,
  parameter int SCALE_W   = 8
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*ELEM_W-1:0] in_elem,
  input  logic [SCALE_W-1:0]          in_scale,
  input  logic                        in_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES*ELEM_W-1:0] out_elem,
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
  input  logic                        ovf_clr,
  output logic [CNT_W-1:0]            ovf_count,
`endif
  output logic [NUM_LANES-1:0]        out_ovf
);
  logic               s1_valid;
  logic               s2_valid;
  logic               s1_ready;
  logic               s2_ready;
  logic               s1_load;
  logic               s2_load;
  logic [SCALE_W-1:0] s1_scale;
  scale_mode_e        s1_mode;
  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign s1_load   = in_valid && s1_ready;
  assign s2_load   = s1_valid && s2_ready;
  assign out_valid = s2_valid;
  // stage valid flags advance whenever the following stage can take the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= s1_ready ? in_valid : s1_valid;
      s2_valid <= s2_ready ? s1_valid : s2_valid;
    end
  end
  // scale and mode ride along with their beat into S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_scale <= '0;
      s1_mode  <= SCALE_ALIGN;
    end else if (s1_load) begin
      s1_scale <= in_scale;
      s1_mode  <= scale_mode_e'(in_mode);
    end
  end
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sm_scale_lane #(.ELEM_W(ELEM_W), .SCALE_W(SCALE_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .s1_load  (s1_load),
      .s2_load  (s2_load),
      .elem     (in_elem[l*ELEM_W +: ELEM_W]),
      .scale    (s1_scale),
      .mode     (s1_mode),
      .out_elem (out_elem[l*ELEM_W +: ELEM_W]),
      .out_ovf  (out_ovf[l])
    );
  end
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
  localparam int PC_W = $clog2(NUM_LANES + 1);
  logic [CNT_W+PC_W-1:0] cnt_sum;
  assign cnt_sum = (CNT_W+PC_W)'(ovf_count) + (CNT_W+PC_W)'($countones(out_ovf));
  // saturating count of overflowed lanes per output handshake; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_count <= '0;
    else if (ovf_clr) ovf_count <= '0;
    else if (out_valid && out_ready)
      ovf_count <= (cnt_sum > (CNT_W+PC_W)'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
  end
`endif
endmodule

// File: tb/tb_sm_scale_pipe.sv
// tb_sm_scale_pipe: table vectors plus scoreboard for sm_scale_pipe
module tb_sm_scale_pipe;
  typedef struct {
    logic [31:0] elem;
    logic [7:0]  scale;
    logic        mode;
    logic [31:0] exp_elem;
    logic [3:0]  exp_ovf;
  } vec_t;
  typedef struct {
    logic [31:0] e;
    logic [3:0]  o;
  } sb_t;

  logic        clk = 0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_elem;
  logic [7:0]  in_scale;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_elem;
  logic [3:0]  out_ovf;
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
  logic        ovf_clr;
  logic [15:0] ovf_count;
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_elem2;
  logic [3:0]  out_ovf2;
  logic [1:0]  ovf_count2;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  sb_t         sb[$];
  int          occ = 0;
  logic        hold_v = 0;
  logic [31:0] hold_e;
  logic [3:0]  hold_o;
  logic [31:0] nx_elem;
  logic [3:0]  nx_ovf;
  logic [3:0]  pat = 4'b1001;
  vec_t        tbl[10];

  always #5 clk = ~clk;

  sm_scale_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_elem   (in_elem),
    .in_scale  (in_scale),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_elem  (out_elem),
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count),
`endif
    .out_ovf   (out_ovf)
  );

`ifdef SM_SCALE_PIPE_OVF_CNT_EN
  sm_scale_pipe #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_elem   (in_elem),
    .in_scale  (in_scale),
    .in_mode   (in_mode),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_elem  (out_elem2),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count2),
    .out_ovf   (out_ovf2)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // reference: value * 2^scale against a 7-bit magnitude ceiling
  function automatic logic [35:0] model(input logic [31:0] e, input logic [7:0] sc, input logic md);
    logic [31:0] r_e;
    logic [3:0]  r_o;
    r_e = '0;
    r_o = '0;
    for (int l = 0; l < 4; l++) begin
      int m;
      int r;
      m = int'(e[l*8 +: 7]);
      r = 0;
      if (m != 0) begin
        if (sc < 7 && (m << sc) < 128) r = m << sc;
        else begin
          r_o[l] = 1'b1;
          if (md) r = 127;
          else begin
            r = m;
            while (r < 64) r = r * 2;
          end
        end
      end
      r_e[l*8 +: 8] = {e[l*8+7], 7'(r)};
    end
    return {r_o, r_e};
  endfunction

  // scoreboard, in_ready occupancy model and stall-hold monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      occ = 0;
      hold_v = 0;
    end else begin
      if (hold_v && out_valid) begin
        check("hold_elem", out_elem, hold_e);
        check("hold_ovf", 32'(out_ovf), 32'(hold_o));
      end
      check("in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_beat: got elem %h, want no beat", out_elem);
        end else begin
          sb_t x;
          x = sb.pop_front();
          check("out_elem", out_elem, x.e);
          check("out_ovf", 32'(out_ovf), 32'(x.o));
        end
      end
      if (in_valid && in_ready) sb.push_back('{nx_elem, nx_ovf});
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      hold_v = out_valid && !out_ready;
      hold_e = out_elem;
      hold_o = out_ovf;
    end
  end

  task automatic send(input logic [31:0] e, input logic [7:0] sc, input logic md,
                      input logic [31:0] xe, input logic [3:0] xo);
    int n;
    n = 0;
    in_elem = e;
    in_scale = sc;
    in_mode = md;
    nx_elem = xe;
    nx_ovf = xo;
    in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0, want 1");
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] se;
    logic [7:0]  ss;
    logic        sm;
    logic [35:0] sx;
    tbl[0] = '{32'h00000005, 8'd3,   1'b0, 32'h00000028, 4'b0000};
    tbl[1] = '{32'h85858585, 8'd5,   1'b0, 32'hD0D0D0D0, 4'b1111};
    tbl[2] = '{32'h85858585, 8'd5,   1'b1, 32'hFFFFFFFF, 4'b1111};
    tbl[3] = '{32'h80808080, 8'd200, 1'b0, 32'h80808080, 4'b0000};
    tbl[4] = '{32'h40404040, 8'd0,   1'b0, 32'h40404040, 4'b0000};
    tbl[5] = '{32'h7F7F7F7F, 8'd255, 1'b0, 32'h7F7F7F7F, 4'b1111};
    tbl[6] = '{32'h01810300, 8'd6,   1'b1, 32'h40C07F00, 4'b0010};
    tbl[7] = '{32'h830C7F01, 8'd2,   1'b0, 32'h8C307F04, 4'b0010};
    tbl[8] = '{32'h830C7F01, 8'd4,   1'b1, 32'hB07F7F10, 4'b0110};
    tbl[9] = '{32'h830C7F01, 8'd4,   1'b0, 32'hB0607F10, 4'b0110};
    rst_n = 0;
    in_valid = 0;
    in_elem = '0;
    in_scale = '0;
    in_mode = 0;
    out_ready = 1;
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
    ovf_clr = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_elem", out_elem, 0);
    check("rst_out_ovf", 32'(out_ovf), 0);
    check("rst_in_ready", 32'(in_ready), 1);
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
    check("rst_ovf_count", 32'(ovf_count), 0);
`endif
    rst_n = 1;
    @(posedge clk);
    #1;
    send(tbl[0].elem, tbl[0].scale, tbl[0].mode, tbl[0].exp_elem, tbl[0].exp_ovf);
    @(negedge clk);
    check("latency_c1", 32'(out_valid), 0);
    @(negedge clk);
    check("latency_c2", 32'(out_valid), 1);
    drain();
    for (int i = 1; i < 10; i++) begin
      send(tbl[i].elem, tbl[i].scale, tbl[i].mode, tbl[i].exp_elem, tbl[i].exp_ovf);
      drain();
    end
    fork
      for (int i = 0; i < 8; i++) begin
        se = $urandom;
        ss = 8'($urandom_range(0, 8));
        sm = 1'($urandom_range(0, 1));
        sx = model(se, ss, sm);
        send(se, ss, sm, sx[31:0], sx[35:32]);
      end
      for (int i = 0; i < 40; i++) begin
        out_ready = pat[i % 4];
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1;
    drain();
`ifdef SM_SCALE_PIPE_OVF_CNT_EN
    ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    for (int i = 0; i < 3; i++) begin
      send(32'h7F7F0101, 8'd3, 1'b0, 32'h7F7F0808, 4'b1100);
      drain();
    end
    check("ovf_count_6", 32'(ovf_count), 6);
    check("ovf_count_sat", 32'(ovf_count2), 3);
    out_ready = 0;
    send(32'h7F7F0101, 8'd3, 1'b0, 32'h7F7F0808, 4'b1100);
    repeat (2) @(posedge clk);
    #1;
    ovf_clr = 1;
    out_ready = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    check("ovf_clr_hs", 32'(ovf_count), 0);
    check("ovf_clr_hs_sat", 32'(ovf_count2), 0);
    drain();
`endif
    out_ready = 0;
    se = $urandom;
    sx = model(se, 8'd1, 1'b0);
    send(se, 8'd1, 1'b0, sx[31:0], sx[35:32]);
    se = $urandom;
    sx = model(se, 8'd2, 1'b1);
    send(se, 8'd2, 1'b1, sx[31:0], sx[35:32]);
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 1);
    check("full_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 0);
    end
    check("post_rst_in_ready", 32'(in_ready), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sm_scale_pipe.md
# sm_scale_pipe

Multi-lane, pipelined sign-magnitude power-of-two scaler for the Operand Transformer. Each lane computes element × 2^scale, preserves the sign and resolves magnitude overflow with a selectable policy (MSB-align or saturate). It sits between the operand fetch stage and the transformed-operand buffer and uses a valid/ready handshake on both sides. It is the parametrised, registered successor of the single-lane combinational scaler.

## Interface
- NUM_LANES, 4: elements processed per beat
- ELEM_W, 8: element width; bit ELEM_W-1 is the sign, the lower MAG_W = ELEM_W-1 bits are the magnitude
- SCALE_W, 8: unsigned scale width
- CNT_W, 16: overflow counter width (only with SM_SCALE_PIPE_OVF_CNT_EN)
- clk  in  1  clock; the block has a single clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat when high
- in_elem  in  NUM_LANES*ELEM_W  lane i at bits [i*ELEM_W +: ELEM_W]
- in_scale  in  SCALE_W  shift amount shared by all lanes of the beat
- in_mode  in  1  0 = ALIGN, 1 = SATURATE
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_elem  out  NUM_LANES*ELEM_W  scaled lanes
- out_ovf  out  NUM_LANES  per-lane overflow flag
- ovf_clr  in  1  synchronous clear of ovf_count (counter builds only)
- ovf_count  out  CNT_W  saturating count of overflowed lanes (counter builds only)

## Operation
- Per lane: sign s, magnitude m, leading-one position p (0..MAG_W-1).
- m == 0: output {s, 0}, ovf = 0, for any scale.
- p + scale ≤ MAG_W-1: output {s, m << scale}, ovf = 0.
- p + scale > MAG_W-1: ovf = 1. ALIGN mode outputs {s, m << (MAG_W-1-p)}. SATURATE mode outputs {s, all-ones}.
- The p + scale sum is evaluated at SCALE_W+1 bits, so it never wraps.
- Scale and mode are captured with the data and travel with their beat.
- The overflow counter adds popcount(out_ovf) on each output handshake (out_valid & out_ready) and saturates at 2^CNT_W-1.
- ovf_clr has priority: when it is asserted the counter becomes 0 that cycle, even if a handshake occurs.

## Timing
- Two register stages:
  - S1 registers the input, the per-lane p and the zero flags.
  - S2 registers the shifted result and ovf.
- Latency is 2 cycles from input handshake to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Stall rules:
  - s2_ready = !s2_valid | out_ready.
  - s1_ready = !s1_valid | s2_ready.
  - in_ready = s1_ready. This is a combinational path from out_ready.
- While out_valid is high and out_ready is low, out_elem and out_ovf hold stable.
- There are no bubbles under continuous backpressure release; no beat is lost or duplicated.
- Reset values: out_valid = 0, out_elem = 0, out_ovf = 0, ovf_count = 0, all stage-valid flags = 0.
- Reset asserted mid-operation drops every in-flight beat immediately.
- After reset, in_ready reads 1.

## Configuration
- SM_SCALE_PIPE_OVF_CNT_EN defined: ovf_clr, ovf_count and the counter logic exist.
- Macro undefined: those ports and the counter are absent. out_ovf is still produced.

## Structure
- operand_tf_pkg holds:
  - the overflow-mode enum typedef (SCALE_ALIGN = 0, SCALE_SAT = 1);
  - the lane-width function computing MAG_W.
- One natural sub-module, sm_scale_lane: the per-lane leading-one detector plus shift/overflow logic. It is split at the S1/S2 boundary and instantiated NUM_LANES times via generate.
- Pipeline control and the counter live in the top.

## Test plan
- Defaults; lane 0x05, scale 3, ALIGN -> 0x28, ovf 0, out_valid exactly 2 cycles after the handshake.
- Lane 0x85, scale 5: ALIGN -> 0xD0, ovf 1. SATURATE -> 0xFF, ovf 1.
- Lane 0x80, scale 200 -> 0x80, ovf 0. Lane 0x40, scale 0 -> 0x40, ovf 0. Lane 0x7F, scale 255 in ALIGN -> 0x7F, ovf 1.
- Stream 8 beats while toggling out_ready 1,0,0,1,…:
  - all 8 beats emerge in order, unchanged;
  - output holds while stalled;
  - in_ready drops only when both stages are full.
- Counter build: 3 beats with 2 overflowed lanes each -> ovf_count = 6. Then ovf_clr together with a handshake -> 0. With CNT_W = 2 the counter saturates at 3.
- Assert rst_n low with 2 beats in flight -> out_valid goes to 0 immediately. After release no stale beat appears and in_ready = 1.
